// File: rtl/axi_burst_copier.sv
// AXI4 master block copier: copies burst_count blocks of BURST_LEN words from src_adr to
// dst_adr, one read burst into a local buffer followed by one write burst out of it.
module axi_burst_copier #(
  parameter int unsigned BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_adr,
  input  logic [31:0] dst_adr,
  input  logic [15:0] burst_count,
  output logic        busy,
  output logic        done,
  // read address channel
  output logic        m_arvalid,
  output logic [31:0] m_aradr,
  output logic [7:0]  m_arlen,
  input  logic        s_arready,
  // read data channel
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  output logic        m_rready,
  // write address channel
  output logic        m_awvalid,
  output logic [31:0] m_awadr,
  output logic [7:0]  m_awlen,
  input  logic        s_awready,
  // write data channel
  output logic        m_wvalid,
  output logic [31:0] m_wdata,
  input  logic        s_wready,
  // write response channel
  input  logic        s_bvalid,
  output logic        m_bready
);

  localparam int unsigned    IdxW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(BURST_LEN - 1);
  localparam logic [31:0]    BlockBytes = 32'(4 * BURST_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StReadAddr,
    StReadData,
    StWriteAddr,
    StWriteData,
    StWriteResp
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [15:0]     remaining_q, remaining_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            done_q, done_d;
  logic            buf_we;
  logic [31:0]     buf_mem [BURST_LEN];

  // State and control registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
    end
  end

  // Burst buffer: filled beat by beat during the read phase, no reset needed.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[idx_q] <= s_rdata;
    end
  end

  // Next-state logic and channel handshakes.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    buf_we      = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          src_d       = {src_adr[31:2], 2'b00};
          dst_d       = {dst_adr[31:2], 2'b00};
          remaining_d = burst_count;
          idx_d       = '0;
          if (burst_count == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StReadAddr;
          end
        end
      end
      StReadAddr: begin
        m_arvalid = 1'b1;
        if (s_arready) state_d = StReadData;
      end
      StReadData: begin
        m_rready = 1'b1;
        // Beat counting alone ends the burst; rlast is not needed.
        if (s_rvalid) begin
          buf_we = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StWriteAddr;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StWriteAddr: begin
        m_awvalid = 1'b1;
        if (s_awready) state_d = StWriteData;
      end
      StWriteData: begin
        m_wvalid = 1'b1;
        if (s_wready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StWriteResp;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StWriteResp: begin
        m_bready = 1'b1;
        if (s_bvalid) begin
          src_d = src_q + BlockBytes;
          dst_d = dst_q + BlockBytes;
          if (remaining_q != 16'd0) remaining_d = remaining_q - 16'd1;
          if (remaining_q <= 16'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StReadAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign m_aradr = src_q;
  assign m_awadr = dst_q;
  assign m_arlen = 8'(BURST_LEN - 1);
  assign m_awlen = 8'(BURST_LEN - 1);
  assign m_wdata = buf_mem[idx_q];
  assign busy    = (state_q != StIdle);
  assign done    = done_q;

endmodule

// File: tb/tb_axi_burst_copier.sv
// Bench for axi_burst_copier: memory slave with optional random stalls, a block-copy reference
// model on a separate memory image, and protocol monitors on the master channels.
module tb_axi_burst_copier;

  localparam int unsigned BL       = 8;
  localparam int          Timeout  = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_adr = '0;
  logic [31:0] dst_adr = '0;
  logic [15:0] burst_count = '0;
  logic        busy, done;
  logic        m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
  logic [31:0] m_aradr, m_awadr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic        s_arready = 1'b0, s_rvalid = 1'b0, s_awready = 1'b0, s_wready = 1'b0;
  logic        s_bvalid = 1'b0;
  logic [31:0] s_rdata = '0;

  always #5 clk = ~clk;

  axi_burst_copier #(.BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
    .burst_count(burst_count), .busy(busy), .done(done),
    .m_arvalid(m_arvalid), .m_aradr(m_aradr), .m_arlen(m_arlen), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awadr(m_awadr), .m_awlen(m_awlen), .s_awready(s_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .m_bready(m_bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Word-addressed memory images: slave-side (written by the DUT) and reference model.
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    return mem.exists(wa) ? mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  // Slave state and transaction logs.
  bit          stall = 1'b0;
  logic [31:0] rd_addr, wr_addr;
  int          rd_left = 0, wr_beat = 0, wr_len = 0;
  bit          aw_seen = 1'b0, b_pend = 1'b0;
  logic [31:0] ar_log[$], aw_log[$];
  logic [7:0]  arlen_log[$], awlen_log[$];
  int          kind_log[$];
  int          done_cnt = 0, viol = 0;
  bit          prev_ar = 1'b0, prev_aw = 1'b0, prev_w = 1'b0;
  logic [31:0] prev_aradr, prev_awadr, prev_wdata;

  function automatic bit rnd_ok();
    return !stall || ($urandom_range(0, 2) == 0);
  endfunction

  // Slave responses and protocol monitors, evaluated at negedge so the DUT outputs are settled
  // and the chosen inputs stay fixed until the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      s_arready = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
      rd_left = 0; wr_beat = 0; aw_seen = 1'b0; b_pend = 1'b0;
      prev_ar = 1'b0; prev_aw = 1'b0; prev_w = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (m_arvalid && m_awvalid) begin
        viol++; $display("FAIL ar_aw_overlap: arvalid and awvalid both high at %0t", $time);
      end
      if (prev_ar && (!m_arvalid || m_aradr !== prev_aradr)) begin
        viol++; $display("FAIL ar_stable: arvalid %0b adr 0x%0h, held 0x%0h", m_arvalid, m_aradr,
                         prev_aradr);
      end
      if (prev_aw && (!m_awvalid || m_awadr !== prev_awadr)) begin
        viol++; $display("FAIL aw_stable: awvalid %0b adr 0x%0h, held 0x%0h", m_awvalid, m_awadr,
                         prev_awadr);
      end
      if (prev_w && (!m_wvalid || m_wdata !== prev_wdata)) begin
        viol++; $display("FAIL w_stable: wvalid %0b data 0x%0h, held 0x%0h", m_wvalid, m_wdata,
                         prev_wdata);
      end
      // responses first, so a new address is never answered in its own handshake cycle
      s_rvalid = (rd_left > 0) && rnd_ok();
      s_rdata  = s_rvalid ? mem_rd(rd_addr >> 2) : 32'h0;
      if (s_rvalid && m_rready) begin
        rd_addr = rd_addr + 32'd4;
        rd_left--;
      end
      s_bvalid = b_pend && rnd_ok();
      if (s_bvalid && m_bready) b_pend = 1'b0;
      s_wready = aw_seen && rnd_ok();
      if (s_wready && m_wvalid) begin
        mem[wr_addr >> 2] = m_wdata;
        wr_addr = wr_addr + 32'd4;
        wr_beat++;
        if (wr_beat == wr_len) begin
          aw_seen = 1'b0; b_pend = 1'b1; wr_beat = 0;
        end
      end
      s_arready = (rd_left == 0) && rnd_ok();
      if (s_arready && m_arvalid) begin
        ar_log.push_back(m_aradr); arlen_log.push_back(m_arlen); kind_log.push_back(0);
        rd_addr = m_aradr; rd_left = int'(m_arlen) + 1;
      end
      s_awready = !aw_seen && !b_pend && rnd_ok();
      if (s_awready && m_awvalid) begin
        aw_log.push_back(m_awadr); awlen_log.push_back(m_awlen); kind_log.push_back(1);
        wr_addr = m_awadr; wr_len = int'(m_awlen) + 1; aw_seen = 1'b1;
      end
      prev_ar = m_arvalid && !s_arready; prev_aradr = m_aradr;
      prev_aw = m_awvalid && !s_awready; prev_awadr = m_awadr;
      prev_w  = m_wvalid && !s_wready;   prev_wdata = m_wdata;
    end
  end

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] count;
    bit          stall;
    logic [31:0] last_ar;
    logic [31:0] last_aw;
  } vec_t;

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valids"}, {m_arvalid, m_awvalid, m_wvalid}, 0);
    check({tag, "_readys"}, {m_rready, m_bready}, 0);
  endtask

  task automatic run_copy(input vec_t v, input string tag);
    logic [31:0] exp_ar[$], exp_aw[$];
    logic [31:0] blk[BL];
    logic [31:0] s0, d0;
    int k, busy_bad, bad;
    bit got;
    stall = v.stall;
    ar_log.delete(); aw_log.delete(); arlen_log.delete(); awlen_log.delete(); kind_log.delete();
    done_cnt = 0; viol = 0;
    src_adr = v.src; dst_adr = v.dst; burst_count = v.count; start = 1'b1;
    tick();
    start = 1'b0;
    // inputs changing while busy must have no effect
    src_adr = $urandom; dst_adr = $urandom; burst_count = 16'($urandom);
    if (v.count == 16'd0) begin
      check({tag, "_zero_done"}, done, 1);
      check({tag, "_zero_busy"}, busy, 0);
      tick();
      check({tag, "_zero_done_off"}, done, 0);
      busy_bad = 0;
      repeat (5) begin
        tick();
        if (busy || m_arvalid || m_awvalid) busy_bad++;
      end
      check({tag, "_zero_quiet"}, busy_bad, 0);
    end else begin
      check({tag, "_busy_start"}, busy, 1);
      check({tag, "_arvalid_start"}, m_arvalid, 1);
      k = 1; got = 1'b0; busy_bad = 0;
      while (k < Timeout && !got) begin
        start = (k == 3);
        tick();
        k++;
        if (done) got = 1'b1;
        else if (!busy) busy_bad++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, got, 1);
      check({tag, "_busy_throughout"}, busy_bad, 0);
      if (!v.stall) check({tag, "_latency"}, k, int'(v.count) * (2 * BL + 3) + 1);
      check({tag, "_busy_at_done"}, busy, 0);
      tick();
      check({tag, "_done_pulse"}, done, 0);
    end
    repeat (3) tick();
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_protocol"}, viol, 0);

    // Reference: block-wise copy, each block read in full before it is written.
    s0 = {v.src[31:2], 2'b00};
    d0 = {v.dst[31:2], 2'b00};
    for (int b = 0; b < int'(v.count); b++) begin
      exp_ar.push_back(s0 + 32'(b * 4 * BL));
      exp_aw.push_back(d0 + 32'(b * 4 * BL));
      for (int i = 0; i < BL; i++) blk[i] = ref_rd((exp_ar[b] + 32'(4 * i)) >> 2);
      for (int i = 0; i < BL; i++) ref_mem[(exp_aw[b] + 32'(4 * i)) >> 2] = blk[i];
    end
    check({tag, "_ar_count"}, ar_log.size(), exp_ar.size());
    check({tag, "_aw_count"}, aw_log.size(), exp_aw.size());
    bad = 0;
    for (int i = 0; i < ar_log.size() && i < exp_ar.size(); i++) begin
      if (ar_log[i] !== exp_ar[i] || arlen_log[i] !== 8'(BL - 1)) bad++;
    end
    for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++) begin
      if (aw_log[i] !== exp_aw[i] || awlen_log[i] !== 8'(BL - 1)) bad++;
    end
    for (int i = 0; i < kind_log.size(); i++) if (kind_log[i] != (i % 2)) bad++;
    check({tag, "_addr_sequence"}, bad, 0);
    if (v.count != 16'd0 && ar_log.size() > 0 && aw_log.size() > 0) begin
      check({tag, "_last_aradr"}, ar_log[$], v.last_ar);
      check({tag, "_last_awadr"}, aw_log[$], v.last_aw);
    end
    bad = 0;
    foreach (ref_mem[a]) if (mem_rd(a) !== ref_mem[a]) bad++;
    foreach (mem[a]) if (mem[a] !== ref_rd(a)) bad++;
    check({tag, "_memory"}, bad, 0);
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0800, 16'd1, 1'b0, 32'h0000_0100, 32'h0000_0800};
    vecs[1] = '{32'h0000_0000, 32'h0000_1000, 16'd3, 1'b0, 32'h0000_0040, 32'h0000_1040};
    vecs[2] = '{32'h0000_5000, 32'h0000_6000, 16'd0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{32'hFFFF_FFE0, 32'h0000_2000, 16'd2, 1'b0, 32'h0000_0000, 32'h0000_2020};
    vecs[4] = '{32'h0000_7003, 32'h0000_8002, 16'd2, 1'b1, 32'h0000_7020, 32'h0000_8020};
    vecs[5] = '{32'h0000_9000, 32'h0000_A000, 16'd4, 1'b1, 32'h0000_9060, 32'h0000_A060};

    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    for (int i = 0; i < 6; i++) run_copy(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.src   = $urandom;
      rv.dst   = $urandom;
      rv.count = 16'($urandom_range(1, 4));
      rv.stall = 1'($urandom_range(0, 1));
      rv.last_ar = {rv.src[31:2], 2'b00} + 32'((int'(rv.count) - 1) * 4 * BL);
      rv.last_aw = {rv.dst[31:2], 2'b00} + 32'((int'(rv.count) - 1) * 4 * BL);
      run_copy(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a write burst.
    stall = 1'b0;
    src_adr = 32'h0000_3000; dst_adr = 32'h0000_4000; burst_count = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int k;
      k = 0;
      while (k < Timeout && !m_wvalid) begin
        tick();
        k++;
      end
      check("abort_reached_write_data", m_wvalid, 1);
    end
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_idle_outputs("abort_async");
    tick();
    check_idle_outputs("abort_held");
    reset = 1'b0;
    // the aborted copy leaves its destination partially written; that content is unspecified
    ref_mem = mem;
    ar_log.delete();
    repeat (3) tick();
    check("abort_stays_idle", {busy, m_arvalid, 1'(ar_log.size() != 0)}, 0);
    rv = '{32'h0000_3000, 32'h0000_C000, 16'd2, 1'b0, 32'h0000_3020, 32'h0000_C020};
    run_copy(rv, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks,
             errors);
    $fatal(1, "watchdog");
  end

endmodule
